// File: rtl/alu_issue.sv
// RV32I integer-ALU issue stage: decodes OP/OP-IMM/LUI/AUIPC, applies the writeback
// bypass to the source operands and holds the result in a single-entry valid/ready register.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        fwd_en,
  input  logic [4:0]  fwd_rd,
  input  logic [31:0] fwd_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  aluop,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [4:0]  rd,
  output logic        we,
  output logic        illegal
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic        valid_r;
  logic [3:0]  aluop_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [4:0]  rd_r;
  logic        we_r;
  logic        illegal_r;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] rs1_val_s;
  logic [31:0] rs2_val_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_u_s;
  logic [31:0] shamt_s;
  logic [3:0]  dec_op_s;
  logic [31:0] dec_a_s;
  logic [31:0] dec_b_s;
  logic        dec_ill_s;
  logic        accept_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u_s  = {instr[31:12], 12'h000};
  assign shamt_s  = {27'd0, instr[24:20]};

  // x0 is never bypassed: a writeback to x0 carries no architectural value.
  assign rs1_val_s = (fwd_en && (fwd_rd != 5'd0) && (fwd_rd == instr[19:15])) ? fwd_data : rs1_data;
  assign rs2_val_s = (fwd_en && (fwd_rd != 5'd0) && (fwd_rd == instr[24:20])) ? fwd_data : rs2_data;

  assign in_ready  = !rst && !flush && (!valid_r || out_ready);
  assign accept_s  = in_valid && in_ready;

  assign out_valid = valid_r;
  assign aluop     = aluop_r;
  assign a         = a_r;
  assign b         = b_r;
  assign rd        = rd_r;
  assign we        = we_r;
  assign illegal   = illegal_r;

  // Instruction decode; illegal encodings fall through to ADD 0,0.
  always_comb begin
    dec_op_s  = ALU_ADD;
    dec_a_s   = 32'd0;
    dec_b_s   = 32'd0;
    dec_ill_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        if (funct7_s == F7_BASE) begin
          dec_a_s = rs1_val_s;
          dec_b_s = rs2_val_s;
          case (funct3_s)
            3'b000:  dec_op_s = ALU_ADD;
            3'b001:  dec_op_s = ALU_SLL;
            3'b010:  dec_op_s = ALU_SLT;
            3'b011:  dec_op_s = ALU_SLTU;
            3'b100:  dec_op_s = ALU_XOR;
            3'b101:  dec_op_s = ALU_SRL;
            3'b110:  dec_op_s = ALU_OR;
            3'b111:  dec_op_s = ALU_AND;
            default: dec_op_s = ALU_ADD;
          endcase
        end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b000)) begin
          dec_op_s = ALU_SUB;
          dec_a_s  = rs1_val_s;
          dec_b_s  = rs2_val_s;
        end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b101)) begin
          dec_op_s = ALU_SRA;
          dec_a_s  = rs1_val_s;
          dec_b_s  = rs2_val_s;
        end else begin
          dec_ill_s = 1'b1;
        end
      end
      OPC_OPIMM: begin
        case (funct3_s)
          3'b000: begin dec_op_s = ALU_ADD;  dec_a_s = rs1_val_s; dec_b_s = imm_i_s; end
          3'b010: begin dec_op_s = ALU_SLT;  dec_a_s = rs1_val_s; dec_b_s = imm_i_s; end
          3'b011: begin dec_op_s = ALU_SLTU; dec_a_s = rs1_val_s; dec_b_s = imm_i_s; end
          3'b100: begin dec_op_s = ALU_XOR;  dec_a_s = rs1_val_s; dec_b_s = imm_i_s; end
          3'b110: begin dec_op_s = ALU_OR;   dec_a_s = rs1_val_s; dec_b_s = imm_i_s; end
          3'b111: begin dec_op_s = ALU_AND;  dec_a_s = rs1_val_s; dec_b_s = imm_i_s; end
          3'b001: begin
            if (funct7_s == F7_BASE) begin
              dec_op_s = ALU_SLL;
              dec_a_s  = rs1_val_s;
              dec_b_s  = shamt_s;
            end else begin
              dec_ill_s = 1'b1;
            end
          end
          3'b101: begin
            if (funct7_s == F7_BASE) begin
              dec_op_s = ALU_SRL;
              dec_a_s  = rs1_val_s;
              dec_b_s  = shamt_s;
            end else if (funct7_s == F7_ALT) begin
              dec_op_s = ALU_SRA;
              dec_a_s  = rs1_val_s;
              dec_b_s  = shamt_s;
            end else begin
              dec_ill_s = 1'b1;
            end
          end
          default: dec_ill_s = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_b_s = imm_u_s;
      end
      OPC_AUIPC: begin
        dec_a_s = pc;
        dec_b_s = imm_u_s;
      end
      default: dec_ill_s = 1'b1;
    endcase
  end

  // Issue register: flush beats accept, accept beats drain, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r   <= 1'b0;
      aluop_r   <= 4'd0;
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      rd_r      <= 5'd0;
      we_r      <= 1'b0;
      illegal_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (accept_s) begin
      valid_r   <= 1'b1;
      aluop_r   <= dec_op_s;
      a_r       <= dec_a_s;
      b_r       <= dec_b_s;
      rd_r      <= instr[11:7];
      we_r      <= !dec_ill_s && (instr[11:7] != 5'd0);
      illegal_r <= dec_ill_s;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed checks of the key scenarios followed by randomized traffic
// compared against a table-driven decode model and a one-slot handshake model.
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        fwd_en;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd;
  logic        we;
  logic        illegal;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_en(fwd_en), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .aluop(aluop), .a(a), .b(b), .rd(rd), .we(we), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Legal encodings: operand form 0 = reg/reg, 1 = I-imm, 2 = shamt, 3 = LUI, 4 = AUIPC.
  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         cf3;
    bit         cf7;
    logic [3:0] op;
    int         form;
  } ent_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  ent_t tbl[21];
  exp_t m_ent;
  logic m_valid;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                      input logic [31:0] r1, input logic [31:0] r2,
                                      input logic fe, input logic [4:0] fr, input logic [31:0] fd);
    exp_t e;
    logic [31:0] v1;
    logic [31:0] v2;
    int hit;
    v1 = (fe && fr != 5'd0 && fr == ins[19:15]) ? fd : r1;
    v2 = (fe && fr != 5'd0 && fr == ins[24:20]) ? fd : r2;
    hit = -1;
    for (int i = 0; i < 21; i++)
      if (tbl[i].opc == ins[6:0] && (!tbl[i].cf3 || tbl[i].f3 == ins[14:12]) &&
          (!tbl[i].cf7 || tbl[i].f7 == ins[31:25]))
        hit = i;
    e.rd  = ins[11:7];
    e.ill = (hit < 0);
    e.we  = !e.ill && ins[11:7] != 5'd0;
    e.op  = 4'd0;
    e.a   = 32'd0;
    e.b   = 32'd0;
    if (hit >= 0) begin
      e.op = tbl[hit].op;
      case (tbl[hit].form)
        0: begin e.a = v1; e.b = v2; end
        1: begin e.a = v1; e.b = 32'(signed'(ins[31:20])); end
        2: begin e.a = v1; e.b = 32'(ins[24:20]); end
        3: begin e.a = 32'd0; e.b = ins[31:12] * 32'd4096; end
        4: begin e.a = p; e.b = ins[31:12] * 32'd4096; end
        default: e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_ent   = '{op: 4'd0, a: 32'd0, b: 32'd0, rd: 5'd0, we: 1'b0, ill: 1'b0};
  endtask

  task automatic chk_outputs();
    chk("out_valid", out_valid, m_valid);
    chk("aluop", aluop, m_ent.op);
    chk("a", a, m_ent.a);
    chk("b", b, m_ent.b);
    chk("rd", rd, m_ent.rd);
    chk("we", we, m_ent.we);
    chk("illegal", illegal, m_ent.ill);
  endtask

  // One clock: check handshake readiness, advance the model at the edge, check registered outputs.
  task automatic cycle();
    logic rdy;
    #1;
    rdy = !rst && !flush && (!m_valid || out_ready);
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    if (rst) model_reset();
    else if (flush) m_valid = 1'b0;
    else if (in_valid && rdy) begin
      m_valid = 1'b1;
      m_ent = ref_decode(instr, pc, rs1_data, rs2_data, fwd_en, fwd_rd, fwd_data);
    end else if (out_ready) m_valid = 1'b0;
    #1;
    chk_outputs();
  endtask

  initial begin
    logic [31:0] ins;
    int k;
    tbl[0]  = '{7'b0110011, 3'd0, 7'h00, 1'b1, 1'b1, 4'd0, 0};
    tbl[1]  = '{7'b0110011, 3'd1, 7'h00, 1'b1, 1'b1, 4'd2, 0};
    tbl[2]  = '{7'b0110011, 3'd2, 7'h00, 1'b1, 1'b1, 4'd3, 0};
    tbl[3]  = '{7'b0110011, 3'd3, 7'h00, 1'b1, 1'b1, 4'd4, 0};
    tbl[4]  = '{7'b0110011, 3'd4, 7'h00, 1'b1, 1'b1, 4'd5, 0};
    tbl[5]  = '{7'b0110011, 3'd5, 7'h00, 1'b1, 1'b1, 4'd6, 0};
    tbl[6]  = '{7'b0110011, 3'd6, 7'h00, 1'b1, 1'b1, 4'd8, 0};
    tbl[7]  = '{7'b0110011, 3'd7, 7'h00, 1'b1, 1'b1, 4'd9, 0};
    tbl[8]  = '{7'b0110011, 3'd0, 7'h20, 1'b1, 1'b1, 4'd1, 0};
    tbl[9]  = '{7'b0110011, 3'd5, 7'h20, 1'b1, 1'b1, 4'd7, 0};
    tbl[10] = '{7'b0010011, 3'd0, 7'h00, 1'b1, 1'b0, 4'd0, 1};
    tbl[11] = '{7'b0010011, 3'd2, 7'h00, 1'b1, 1'b0, 4'd3, 1};
    tbl[12] = '{7'b0010011, 3'd3, 7'h00, 1'b1, 1'b0, 4'd4, 1};
    tbl[13] = '{7'b0010011, 3'd4, 7'h00, 1'b1, 1'b0, 4'd5, 1};
    tbl[14] = '{7'b0010011, 3'd6, 7'h00, 1'b1, 1'b0, 4'd8, 1};
    tbl[15] = '{7'b0010011, 3'd7, 7'h00, 1'b1, 1'b0, 4'd9, 1};
    tbl[16] = '{7'b0010011, 3'd1, 7'h00, 1'b1, 1'b1, 4'd2, 2};
    tbl[17] = '{7'b0010011, 3'd5, 7'h00, 1'b1, 1'b1, 4'd6, 2};
    tbl[18] = '{7'b0010011, 3'd5, 7'h20, 1'b1, 1'b1, 4'd7, 2};
    tbl[19] = '{7'b0110111, 3'd0, 7'h00, 1'b0, 1'b0, 4'd0, 3};
    tbl[20] = '{7'b0010111, 3'd0, 7'h00, 1'b0, 1'b0, 4'd0, 4};

    rst = 1'b1; in_valid = 1'b0; instr = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    fwd_en = 1'b0; fwd_rd = 5'd0; fwd_data = 32'd0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk_outputs();
    rst = 1'b0;

    // ADDI x5,x1,-1
    instr = 32'hFFF08293; rs1_data = 32'h00000010; in_valid = 1'b1;
    cycle();
    chk("addi_op", aluop, 4'b0000); chk("addi_a", a, 32'h00000010);
    chk("addi_b", b, 32'hFFFFFFFF); chk("addi_rd", rd, 5'd5); chk("addi_we", we, 1'b1);

    // SUB x3,x1,x2 with and without a bypass hit
    out_ready = 1'b1; instr = 32'h402081B3; rs2_data = 32'h00000055;
    fwd_en = 1'b1; fwd_rd = 5'd2; fwd_data = 32'h00000007;
    cycle();
    chk("sub_op", aluop, 4'b0001); chk("sub_fwd_b", b, 32'h00000007);
    fwd_rd = 5'd0;
    cycle();
    chk("sub_nofwd_b", b, 32'h00000055);
    fwd_en = 1'b0;

    // Backpressure: held entry stays put, then AUIPC loads on release
    out_ready = 1'b0; instr = 32'h12345097; pc = 32'h00000100;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold_b", b, 32'h00000055);
    end
    out_ready = 1'b1;
    cycle();
    chk("auipc_op", aluop, 4'b0000); chk("auipc_a", a, 32'h00000100); chk("auipc_b", b, 32'h12345000);

    instr = 32'h4030D093;
    cycle();
    chk("srai_op", aluop, 4'b0111); chk("srai_b", b, 32'h00000003);

    instr = 32'h00000000;
    cycle();
    chk("zero_ill", illegal, 1'b1); chk("zero_we", we, 1'b0); chk("zero_valid", out_valid, 1'b1);

    flush = 1'b1; instr = 32'hFFF08293;
    cycle();
    chk("flush_valid", out_valid, 1'b0);
    flush = 1'b0;

    // Reset while an entry is held
    out_ready = 1'b0;
    cycle();
    chk("pre_rst_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_outputs();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        k = $urandom_range(0, 20);
        ins = $urandom;
        ins[6:0] = tbl[k].opc;
        if (tbl[k].cf3) ins[14:12] = tbl[k].f3;
        if (tbl[k].cf7) ins[31:25] = tbl[k].f7;
      end else begin
        ins = $urandom;
        if ($urandom_range(0, 1) == 0) ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'b0110011 : 7'b0010011;
      end
      if ($urandom_range(0, 1) == 0) ins[19:15] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) ins[24:20] = 5'($urandom_range(0, 3));
      instr     = ins;
      pc        = $urandom;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      fwd_en    = 1'($urandom_range(0, 1));
      fwd_rd    = 5'($urandom_range(0, 3));
      fwd_data  = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
